// File: rtl/hop_cnt_stamper_pkg.sv
// Shared flit-format definitions: type encodings and field positions used by the
// hop-count stamper and by the switch arbiters that read the hop count back.
package hop_cnt_stamper_pkg;

    localparam int TYPE_W  = 2;
    localparam int HOP_LSB = 0;

    typedef enum logic [TYPE_W-1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_TAIL   = 2'b01,
        FLIT_HEAD   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic {
        FRM_IDLE,
        FRM_IN_PKT
    } frame_state_e;

    // The type field sits in the top TYPE_W bits of the flit.
    function automatic int type_lsb(input int flit_w);
        return flit_w - TYPE_W;
    endfunction

    function automatic logic is_header(input flit_type_e t);
        return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
    endfunction

endpackage

// File: rtl/hop_cnt_stamper_if.sv
// Valid/ready flit channel; master drives flit/vld, slave drives rdy.
interface hop_cnt_stamper_if #(
    parameter int FLIT_W = 16
);
    logic [FLIT_W-1:0] flit;
    logic              vld;
    logic              rdy;

    modport master (output flit, output vld, input  rdy);
    modport slave  (input  flit, input  vld, output rdy);
endinterface

// File: rtl/hop_cnt_stamper_skid_buffer_2.sv
// Generic 2-entry valid/ready skid buffer, FIFO order, 1 item/cycle sustained.
// push_rdy depends only on registered occupancy, never on pop_rdy.
module skid_buffer_2 #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] push_data,
    input  logic         push_vld,
    output logic         push_rdy,
    output logic [W-1:0] pop_data,
    output logic         pop_vld,
    input  logic         pop_rdy
);
    logic [W-1:0] ent0_q;
    logic [W-1:0] ent1_q;
    logic [1:0]   cnt_q;
    logic         push;
    logic         pop;

    assign push_rdy = (cnt_q != 2'd2);
    assign pop_vld  = (cnt_q != 2'd0);
    assign pop_data = ent0_q;
    assign push     = push_vld & push_rdy;
    assign pop      = pop_vld & pop_rdy;

    // ent0 is always the head; ent1 only holds data when two entries are live.
    always_ff @(posedge clk_i) begin
        // NOTE: the entries are reset too because ent0 drives pop_data directly and must read 0 out of reset.
        if (!rst_ni) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) ent0_q <= push_data;
                    else               ent1_q <= push_data;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    ent0_q <= ent1_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        ent0_q <= push_data;
                    end else begin
                        ent0_q <= ent1_q;
                        ent1_q <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/hop_cnt_stamper.sv
// Output-port flit stage: increments (saturating) the hop count of every header,
// tracks packet framing, and buffers flits in a 2-entry skid buffer.
module hop_cnt_stamper
    import hop_cnt_stamper_pkg::*;
#(
    parameter int FLIT_W    = 16,
    parameter int HOP_CNT_W = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    hop_cnt_stamper_if.slave  in_if,
    hop_cnt_stamper_if.master out_if,
    output logic sat_o,
    output logic proto_err_o
);
    localparam int                   TYPE_LSB = type_lsb(FLIT_W);
    localparam logic [HOP_CNT_W-1:0] HOP_MAX  = {HOP_CNT_W{1'b1}};
    localparam logic [HOP_CNT_W-1:0] HOP_ONE  = {{(HOP_CNT_W-1){1'b0}}, 1'b1};

    flit_type_e         in_type;
    logic [HOP_CNT_W-1:0] hop;
    logic               hdr;
    logic               hop_at_max;
    logic               accept;
    logic [FLIT_W-1:0]  stamped;

    frame_state_e state_q;
    frame_state_e state_d;
    logic         err_set;
    logic         sat_q;
    logic         err_q;

    assign in_type    = flit_type_e'(in_if.flit[TYPE_LSB +: TYPE_W]);
    assign hop        = in_if.flit[HOP_LSB +: HOP_CNT_W];
    assign hdr        = is_header(in_type);
    assign hop_at_max = (hop == HOP_MAX);
    assign accept     = in_if.vld & in_if.rdy;

    // Stamp before storing so the buffer only ever holds outgoing flits.
    always_comb begin
        stamped = in_if.flit;
        if (hdr && !hop_at_max) stamped[HOP_LSB +: HOP_CNT_W] = hop + HOP_ONE;
    end

    skid_buffer_2 #(.W(FLIT_W)) u_buf (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push_data(stamped),
        .push_vld (in_if.vld),
        .push_rdy (in_if.rdy),
        .pop_data (out_if.flit),
        .pop_vld  (out_if.vld),
        .pop_rdy  (out_if.rdy)
    );

    // A misplaced header still opens (or closes) a packet according to its own type.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_d = state_q;
        err_set = 1'b0;
        if (accept) begin
            unique case (state_q)
                FRM_IDLE: begin
                    if (hdr) state_d = (in_type == FLIT_HEAD) ? FRM_IN_PKT : FRM_IDLE;
                    else     err_set = 1'b1;
                end
                FRM_IN_PKT: begin
                    if (hdr) begin
                        err_set = 1'b1;
                        state_d = (in_type == FLIT_HEAD) ? FRM_IN_PKT : FRM_IDLE;
                    end else begin
                        state_d = (in_type == FLIT_BODY) ? FRM_IN_PKT : FRM_IDLE;
                    end
                end
                default: state_d = FRM_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!rst_ni) begin
            state_q <= FRM_IDLE;
            sat_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sat_q   <= accept & hdr & hop_at_max;
            err_q   <= err_q | err_set;
        end
    end

    assign sat_o       = sat_q;
    assign proto_err_o = err_q;

endmodule

// File: tb/tb_hop_cnt_stamper.sv
// Self-checking bench for hop_cnt_stamper: single-flit vector table, directed
// multi-cycle sequences, and randomized traffic against a queue-based model.
module tb_hop_cnt_stamper;

    logic clk = 1'b0;
    logic rst_n;
    logic sat, perr;

    hop_cnt_stamper_if #(.FLIT_W(16)) in_if ();
    hop_cnt_stamper_if #(.FLIT_W(16)) out_if ();

    hop_cnt_stamper #(.FLIT_W(16), .HOP_CNT_W(3)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_if      (in_if),
        .out_if     (out_if),
        .sat_o      (sat),
        .proto_err_o(perr)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_if.vld  = 1'b0;
        in_if.flit = '0;
        rst_n      = 1'b0;
        tick();
        rst_n      = 1'b1;
    endtask

    task automatic offer(input logic [15:0] f);
        in_if.flit = f;
        in_if.vld  = 1'b1;
    endtask

    typedef struct {
        logic [15:0] in_flit;
        logic [15:0] exp_flit;
        logic        exp_sat;
        logic        exp_err;
    } vec_t;

    // Model of the stage from the behavioural rules: stamp, FIFO of depth 2, framing.
    function automatic logic [15:0] model_stamp(input logic [15:0] f);
        int h;
        logic [15:0] r;
        r = f;
        if (f[15]) begin
            h = int'(f[2:0]) + 1;
            if (h > 7) h = 7;
            r[2:0] = h[2:0];
        end
        return r;
    endfunction

    initial begin
        vec_t vecs[8];
        logic [15:0] q[$];
        logic        m_in_pkt, m_err, m_sat;
        logic        acc, emit;
        logic [15:0] f;

        vecs[0] = '{16'h8002, 16'h8003, 1'b0, 1'b0};
        vecs[1] = '{16'h8007, 16'h8007, 1'b1, 1'b0};
        vecs[2] = '{16'hC005, 16'hC006, 1'b0, 1'b0};
        vecs[3] = '{16'h8000, 16'h8001, 1'b0, 1'b0};
        vecs[4] = '{16'h0011, 16'h0011, 1'b0, 1'b1};
        vecs[5] = '{16'h4ABC, 16'h4ABC, 1'b0, 1'b1};
        vecs[6] = '{16'hC007, 16'hC007, 1'b1, 1'b0};
        vecs[7] = '{16'hBFF8, 16'hBFF9, 1'b0, 1'b0};

        out_if.rdy = 1'b1;
        do_reset();
        check("reset out_vld", out_if.vld, 0);
        check("reset in_rdy", in_if.rdy, 1);
        check("reset sat", sat, 0);
        check("reset perr", perr, 0);
        check("reset out_flit", out_if.flit, 0);

        // Table: one flit from a fresh reset, output one cycle later
        for (int i = 0; i < 8; i++) begin
            do_reset();
            out_if.rdy = 1'b1;
            offer(vecs[i].in_flit);
            tick();
            in_if.vld = 1'b0;
            check($sformatf("vec%0d out_vld", i), out_if.vld, 1);
            check($sformatf("vec%0d out_flit", i), out_if.flit, vecs[i].exp_flit);
            check($sformatf("vec%0d sat", i), sat, vecs[i].exp_sat);
            check($sformatf("vec%0d perr", i), perr, vecs[i].exp_err);
            tick();
            check($sformatf("vec%0d sat 1cyc", i), sat, 0);
            check($sformatf("vec%0d drained", i), out_if.vld, 0);
            check($sformatf("vec%0d perr sticky", i), perr, vecs[i].exp_err);
        end

        // Packet at full rate
        do_reset();
        out_if.rdy = 1'b1;
        offer(16'h8001); tick();
        check("pkt head", out_if.flit, 16'h8002);
        check("pkt rdy0", in_if.rdy, 1);
        offer(16'h1234); tick();
        check("pkt body", out_if.flit, 16'h1234);
        check("pkt rdy1", in_if.rdy, 1);
        offer(16'h4ABC); tick();
        check("pkt tail", out_if.flit, 16'h4ABC);
        check("pkt rdy2", in_if.rdy, 1);
        in_if.vld = 1'b0; tick();
        check("pkt drained", out_if.vld, 0);
        check("pkt perr", perr, 0);

        // Backpressure
        do_reset();
        out_if.rdy = 1'b0;
        offer(16'h8003); tick();
        check("bp rdy after 1", in_if.rdy, 1);
        check("bp head", out_if.flit, 16'h8004);
        offer(16'h0055); tick();
        check("bp rdy after 2", in_if.rdy, 0);
        check("bp stable0", out_if.flit, 16'h8004);
        offer(16'h4066); tick();
        check("bp stable1", out_if.flit, 16'h8004);
        check("bp vld", out_if.vld, 1);
        tick();
        check("bp stable2", out_if.flit, 16'h8004);
        out_if.rdy = 1'b1; tick();
        check("bp out1", out_if.flit, 16'h0055);
        check("bp rdy reopen", in_if.rdy, 1);
        tick();
        in_if.vld = 1'b0;
        check("bp out2", out_if.flit, 16'h4066);
        check("bp vld2", out_if.vld, 1);
        tick();
        check("bp empty", out_if.vld, 0);
        check("bp perr", perr, 0);

        // Header inside packet
        do_reset();
        out_if.rdy = 1'b1;
        offer(16'h8001); tick();
        offer(16'h8002); tick();
        in_if.vld = 1'b0;
        check("hh second stamped", out_if.flit, 16'h8003);
        check("hh perr", perr, 1);
        tick();
        check("hh perr sticky", perr, 1);

        // Reset mid-packet
        do_reset();
        out_if.rdy = 1'b0;
        offer(16'h8001); tick();
        offer(16'h1234); tick();
        in_if.vld = 1'b0;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check("rst out_vld", out_if.vld, 0);
        check("rst in_rdy", in_if.rdy, 1);
        check("rst perr", perr, 0);
        check("rst out_flit", out_if.flit, 0);
        out_if.rdy = 1'b1;
        offer(16'h4ABC); tick();
        in_if.vld = 1'b0;
        check("rst tail perr", perr, 1);
        check("rst tail flit", out_if.flit, 16'h4ABC);

        // Randomized traffic against the model
        do_reset();
        q.delete();
        m_in_pkt = 1'b0;
        m_err    = 1'b0;
        m_sat    = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            check("rnd out_vld", out_if.vld, (q.size() != 0));
            if (q.size() != 0) check("rnd out_flit", out_if.flit, q[0]);
            check("rnd in_rdy", in_if.rdy, (q.size() < 2));
            check("rnd sat", sat, m_sat);
            check("rnd perr", perr, m_err);

            f = 16'($urandom());
            in_if.flit = f;
            in_if.vld  = ($urandom_range(0, 3) != 0);
            out_if.rdy = ($urandom_range(0, 2) != 0);

            acc  = in_if.vld && (q.size() < 2);
            emit = (q.size() != 0) && out_if.rdy;
            m_sat = acc && f[15] && (f[2:0] == 3'd7);
            if (emit) void'(q.pop_front());
            if (acc) begin
                q.push_back(model_stamp(f));
                if (f[15]) begin
                    if (m_in_pkt) m_err = 1'b1;
                    m_in_pkt = (f[15:14] == 2'b10);
                end else begin
                    if (!m_in_pkt) m_err = 1'b1;
                    m_in_pkt = m_in_pkt && (f[15:14] == 2'b00);
                end
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hop_cnt_stamper.md
Name: hop_cnt_stamper

Overview:
Per-output-port flit stage that writes the hop-count field consumed by the switch's hop-count arbitration. On every packet header leaving the router it increments the hop count, saturating at the maximum. Body and tail flits pass through unchanged. It sits between the crossbar output and the link register, with valid/ready handshakes on both sides and a 2-entry skid buffer for full throughput. It tracks packet framing and flags protocol violations.

Parameters:
FLIT_W, 16, total flit width in bits; must be >= HOP_CNT_W+2.
HOP_CNT_W, 3, hop-count field width; the field occupies flit[HOP_CNT_W-1:0] in head and single flits.
TYPE_W, 2, flit type field width; the field occupies flit[FLIT_W-1 -: TYPE_W]. Fixed at 2.

Ports:
clk_i  input  1  clock; all logic on the rising edge.
rst_ni  input  1  reset; synchronous, active-low.
in_flit_i  input  FLIT_W  flit from the crossbar.
in_vld_i  input  1  in_flit_i is valid.
in_rdy_o  output  1  stage can accept; registered (not combinational from out_rdy_i).
out_flit_o  output  FLIT_W  stamped flit to the link.
out_vld_o  output  1  out_flit_o is valid.
out_rdy_i  input  1  downstream accepts.
sat_o  output  1  one-cycle pulse: an accepted header already held the maximum hop count.
proto_err_o  output  1  sticky framing-violation flag.

Behaviour:
- Flit types: HEAD=2'b10, BODY=2'b00, TAIL=2'b01, SINGLE=2'b11 (head and tail in one flit).
- Accept occurs on in_vld_i & in_rdy_o. Emit occurs on out_vld_o & out_rdy_i.
- Stamping happens on accept, before the flit is stored.
  - HEAD/SINGLE: hop field becomes min(hop+1, 2^HOP_CNT_W-1). All other bits are unchanged.
  - If hop was already 2^HOP_CNT_W-1: the field stays at max, and sat_o pulses high in the cycle after the accept.
  - BODY/TAIL: stored bit-exact.
- Buffer: 2-entry skid, FIFO order.
  - out_flit_o/out_vld_o are driven from the head entry.
  - in_rdy_o = 1 when at most one entry is occupied after the current cycle's updates, so the stage sustains 1 flit/cycle with out_rdy_i held high.
  - Latency: an accepted flit appears on out_flit_o the next cycle.
  - Empty buffer: out_vld_o=0. Full buffer: in_rdy_o=0.
  - Accept and emit in the same cycle with one entry occupied: occupancy stays 1, and the new flit becomes the head the next cycle.
  - out_flit_o stays stable while out_vld_o=1 and out_rdy_i=0.
- Framing FSM, advanced on accept only:
  - IDLE: HEAD -> IN_PKT; SINGLE -> IDLE; BODY or TAIL -> set proto_err_o, stay IDLE.
  - IN_PKT: BODY -> IN_PKT; TAIL -> IDLE; HEAD or SINGLE -> set proto_err_o, treat as a new header (stamped), next state per its type.
  - Violating flits are still forwarded, never dropped. proto_err_o clears only on reset.
- Reset (rst_ni=0 at an edge): buffer emptied, FSM=IDLE.
  - Reset output values: out_vld_o=0, in_rdy_o=1, sat_o=0, proto_err_o=0, out_flit_o=0.
  - Reset mid-packet discards buffered flits. The next accepted flit is framed from IDLE.
- A HEAD with hop=0 becomes hop=1. Invalid inputs (in_vld_i=0) never alter state.

Decomposition:
- Shared package/header: flit type encodings (FLIT_HEAD, FLIT_BODY, FLIT_TAIL, FLIT_SINGLE), TYPE_W, field position macros for the type and hop-count fields.
- These are the same definitions used to extract hop counts for the switch arbiters. Both sides must include them from one place.
- One natural sub-module: skid_buffer_2 (generic FLIT_W-wide 2-entry valid/ready buffer). The stamper instantiates it and keeps the FSM and stamping logic locally.

Test Plan:
(FLIT_W=16, HOP_CNT_W=3 throughout.)
- Single HEAD: 16'h8002 with out_rdy_i=1 -> out_flit_o=16'h8003 one cycle after accept; sat_o=0; proto_err_o=0.
- Saturation: HEAD 16'h8007 -> out_flit_o=16'h8007; sat_o=1 for exactly one cycle. SINGLE 16'hC005 -> 16'hC006.
- Packet HEAD 16'h8001, BODY 16'h1234, TAIL 16'h4ABC at 1 flit/cycle with out_rdy_i=1 -> outputs 16'h8002, 16'h1234, 16'h4ABC on consecutive cycles; in_rdy_o stays 1.
- Backpressure: out_rdy_i=0 while 3 flits offered -> 2 accepted, in_rdy_o=0 from the cycle after the 2nd accept, out_flit_o stable. Release out_rdy_i -> order preserved, no loss or duplication.
- Framing error: BODY 16'h0011 from IDLE -> forwarded unchanged, proto_err_o=1 and stays 1. HEAD, then HEAD -> second header stamped, proto_err_o=1.
- Reset mid-packet: after HEAD accepted plus one buffered flit, drive rst_ni=0 for 1 cycle -> out_vld_o=0, in_rdy_o=1, proto_err_o=0. Following TAIL sets proto_err_o (FSM is IDLE).
